// File: rtl/rsa_cmd_ctrl.sv
// Run-control sequencer for the RSA core: merges GPIO/SPI start/stop pulses,
// launches/aborts the core, runs a watchdog and keeps sticky status flags.
module rsa_cmd_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             gpio_start_cmd,
  input  logic             gpio_stop_cmd,
  input  logic             spi_start_cmd,
  input  logic             spi_stop_cmd,
  input  logic [CNT_W-1:0] timeout_cycles,
  input  logic             clear_status,
  input  logic             core_done,
  output logic             core_start,
  output logic             core_abort,
  output logic             busy,
  output logic             done_flag,
  output logic             abort_flag,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] run_cycles,
  output logic             irq
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [CNT_W-1:0] run_cycles_r, run_cycles_n;
  logic             core_start_r, core_start_n;
  logic             core_abort_r, core_abort_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             abort_r, abort_n;
  logic             timeout_r, timeout_n;
  logic             start_s, stop_s, wd_hit_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Increment that clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    if (x == {CNT_W{1'b1}}) begin
      return x;
    end else begin
      return x + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign start_s   = gpio_start_cmd | spi_start_cmd;
  assign stop_s    = gpio_stop_cmd | spi_stop_cmd;
  assign cnt_inc_s = sat_inc(cnt_r);
  assign wd_hit_s  = (timeout_cycles != {CNT_W{1'b0}}) && (cnt_r == timeout_cycles);

  // Next-state and output decode; clear_status is applied first so a
  // same-cycle flag-set event overrides it for that flag only.
  always_comb begin
    state_n      = state_r;
    cnt_n        = cnt_r;
    run_cycles_n = run_cycles_r;
    core_start_n = 1'b0;
    core_abort_n = 1'b0;
    busy_n       = busy_r;
    done_n       = done_r;
    abort_n      = abort_r;
    timeout_n    = timeout_r;
    if (ena) begin
      if (clear_status) begin
        done_n    = 1'b0;
        abort_n   = 1'b0;
        timeout_n = 1'b0;
      end else begin
        done_n    = done_r;
      end
      case (state_r)
        S_IDLE: begin
          if (start_s && !stop_s) begin
            state_n      = S_RUN;
            core_start_n = 1'b1;
            busy_n       = 1'b1;
            cnt_n        = {CNT_W{1'b0}};
            done_n       = 1'b0;
            abort_n      = 1'b0;
            timeout_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_RUN: begin
          if (core_done) begin
            state_n      = S_IDLE;
            busy_n       = 1'b0;
            done_n       = 1'b1;
            run_cycles_n = cnt_inc_s;
          end else if (stop_s) begin
            state_n      = S_IDLE;
            busy_n       = 1'b0;
            core_abort_n = 1'b1;
            abort_n      = 1'b1;
            run_cycles_n = cnt_inc_s;
          end else if (wd_hit_s) begin
            state_n      = S_IDLE;
            busy_n       = 1'b0;
            core_abort_n = 1'b1;
            timeout_n    = 1'b1;
            run_cycles_n = cnt_inc_s;
          end else begin
            cnt_n = cnt_inc_s;
          end
        end
        default: begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      run_cycles_r <= {CNT_W{1'b0}};
      core_start_r <= 1'b0;
      core_abort_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      abort_r      <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_n;
      cnt_r        <= cnt_n;
      run_cycles_r <= run_cycles_n;
      core_start_r <= core_start_n;
      core_abort_r <= core_abort_n;
      busy_r       <= busy_n;
      done_r       <= done_n;
      abort_r      <= abort_n;
      timeout_r    <= timeout_n;
    end
  end

  assign core_start   = core_start_r;
  assign core_abort   = core_abort_r;
  assign busy         = busy_r;
  assign done_flag    = done_r;
  assign abort_flag   = abort_r;
  assign timeout_flag = timeout_r;
  assign run_cycles   = run_cycles_r;
  assign irq          = done_r | abort_r | timeout_r;

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Self-checking bench for rsa_cmd_ctrl: per-cycle vector table plus
// hand-written sequences for long runs and counter saturation.
module tb_rsa_cmd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, gs, gp, ss, sp, dn, cl;
  logic [15:0] tmo;
  logic        cs, ca, bz, df, af, tf, irq;
  logic [15:0] rc;

  logic        e4, gs4, dn4;
  logic [3:0]  tmo4;
  logic        cs4, ca4, bz4, df4, af4, tf4, irq4;
  logic [3:0]  rc4;

  int checks = 0;
  int errors = 0;

  rsa_cmd_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .gpio_start_cmd(gs), .gpio_stop_cmd(gp),
    .spi_start_cmd(ss), .spi_stop_cmd(sp),
    .timeout_cycles(tmo), .clear_status(cl), .core_done(dn),
    .core_start(cs), .core_abort(ca), .busy(bz),
    .done_flag(df), .abort_flag(af), .timeout_flag(tf),
    .run_cycles(rc), .irq(irq)
  );

  rsa_cmd_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .ena(e4),
    .gpio_start_cmd(gs4), .gpio_stop_cmd(1'b0),
    .spi_start_cmd(1'b0), .spi_stop_cmd(1'b0),
    .timeout_cycles(tmo4), .clear_status(1'b0), .core_done(dn4),
    .core_start(cs4), .core_abort(ca4), .busy(bz4),
    .done_flag(df4), .abort_flag(af4), .timeout_flag(tf4),
    .run_cycles(rc4), .irq(irq4)
  );

  typedef struct {
    logic        rst, ena, gs, gp, ss, sp, dn, cl;
    logic [15:0] tmo;
    logic        cs, ca, bz, df, af, tf;
    logic [15:0] rc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, e, g_s, g_p, s_s, s_p, d, c,
                              input logic [15:0] t,
                              input logic x_cs, x_ca, x_bz, x_df, x_af, x_tf,
                              input logic [15:0] x_rc);
    vec_t v;
    v.rst = r; v.ena = e; v.gs = g_s; v.gp = g_p; v.ss = s_s; v.sp = s_p;
    v.dn = d; v.cl = c; v.tmo = t;
    v.cs = x_cs; v.ca = x_ca; v.bz = x_bz; v.df = x_df; v.af = x_af; v.tf = x_tf;
    v.rc = x_rc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; ena = 1'b1; gs = 1'b0; gp = 1'b0; ss = 1'b0; sp = 1'b0;
    dn = 1'b0; cl = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tmo = 16'd0;
    e4 = 1'b1; gs4 = 1'b0; dn4 = 1'b0; tmo4 = 4'd0;

    //   rst ena gs gp ss sp dn cl  tmo  | cs ca bz df af tf  rc
    add(1, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 0, 0, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 0, 0, 0, 0, 16'd0);
    // launch, done after 5 RUN cycles
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0, 0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 16'd0,  0, 0, 0, 1, 0, 0, 16'd5);
    add(0, 1, 0, 0, 0, 0, 0, 1, 16'd0,  0, 0, 0, 0, 0, 0, 16'd5);
    // SPI launch, GPIO stop after 3 RUN cycles
    add(0, 1, 0, 0, 1, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd5);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd5);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd5);
    add(0, 1, 0, 1, 0, 0, 0, 0, 16'd0,  0, 1, 0, 0, 1, 0, 16'd3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 0, 0, 1, 0, 16'd3);
    // start+stop together in IDLE, and stop alone: no effect
    add(0, 1, 1, 0, 0, 1, 0, 0, 16'd0,  0, 0, 0, 0, 1, 0, 16'd3);
    add(0, 1, 0, 1, 0, 0, 0, 0, 16'd0,  0, 0, 0, 0, 1, 0, 16'd3);
    // watchdog limit 4
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd4,  1, 0, 1, 0, 0, 0, 16'd3);
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 0, 0, 0, 0, 16'd4, 0, 0, 1, 0, 0, 0, 16'd3);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd4,  0, 1, 0, 0, 0, 1, 16'd5);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd4,  0, 0, 0, 0, 0, 1, 16'd5);
    // start in RUN ignored; done beats stop
    add(0, 1, 0, 0, 1, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd5);
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd5);
    add(0, 1, 0, 0, 0, 1, 1, 0, 16'd0,  0, 0, 0, 1, 0, 0, 16'd2);
    // clear_status together with done: done wins
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd2);
    add(0, 1, 0, 0, 0, 0, 1, 1, 16'd0,  0, 0, 0, 1, 0, 0, 16'd1);
    // reset mid-run: no abort, everything back to 0
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd1);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd1);
    add(1, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 0, 0, 0, 0, 16'd0);
    // ena=0 for 5 cycles mid-run; pulses during that window are lost
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 16'd0,  0, 0, 0, 1, 0, 0, 16'd2);
    // limit lowered mid-run takes effect at once
    add(0, 1, 1, 0, 0, 0, 0, 0, 16'd0,  1, 0, 1, 0, 0, 0, 16'd2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd0,  0, 0, 1, 0, 0, 0, 16'd2);
    add(0, 1, 0, 0, 0, 0, 0, 0, 16'd2,  0, 1, 0, 0, 0, 1, 16'd3);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; ena = vecs[i].ena;
      gs = vecs[i].gs; gp = vecs[i].gp; ss = vecs[i].ss; sp = vecs[i].sp;
      dn = vecs[i].dn; cl = vecs[i].cl; tmo = vecs[i].tmo;
      step();
      check($sformatf("vec%0d {cs,ca,busy,done,abort,tmo,irq,run}", i),
            {9'd0, cs, ca, bz, df, af, tf, irq, rc},
            {9'd0, vecs[i].cs, vecs[i].ca, vecs[i].bz, vecs[i].df, vecs[i].af,
             vecs[i].tf, (vecs[i].df | vecs[i].af | vecs[i].tf), vecs[i].rc});
    end

    // watchdog disabled: stays busy for 1000 cycles, then done
    idle_inputs();
    tmo = 16'd0;
    gs = 1'b1;
    step();
    gs = 1'b0;
    begin
      int drops = 0;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (bz !== 1'b1 || ca !== 1'b0) drops++;
      end
      check("wd_off_busy_drops", drops, 0);
    end
    dn = 1'b1;
    step();
    dn = 1'b0;
    check("wd_off_run_cycles", rc, 16'd1001);
    check("wd_off_done_busy", {df, tf, bz}, 3'b100);

    // 4-bit instance: cycle count saturates at 15
    check("sat_reset_run", rc4, 4'd0);
    gs4 = 1'b1;
    step();
    gs4 = 1'b0;
    check("sat_launch", {cs4, bz4}, 2'b11);
    for (int i = 0; i < 39; i++) step();
    check("sat_still_busy", {bz4, ca4}, 2'b10);
    dn4 = 1'b1;
    step();
    dn4 = 1'b0;
    check("sat_run_cycles", rc4, 4'd15);
    check("sat_done_flag", {df4, irq4, bz4}, 3'b110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
